// File: rtl/ifu.sv
// Instruction fetch unit: reads a byte-wide instruction memory and assembles
// 1-4 byte instructions, presented to the ECU over a valid/ready handshake.
module ifu #(
    parameter int                 ADDR_W    = 16,
    parameter logic [ADDR_W-1:0]  RESET_VEC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       raw,
    output logic [1:0]        len,
    output logic [ADDR_W-1:0] insn_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr
);

    localparam logic [1:0] S_OP    = 2'd0;
    localparam logic [1:0] S_OPND  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic [31:0]       raw_q, raw_d;
    logic [1:0]        len_q, len_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;
    logic [1:0]        idx_q, idx_d;

    always_comb begin
        // NOTE: every next-state signal defaults to its current value so no path infers a latch.
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        raw_d   = raw_q;
        len_d   = len_q;
        ipc_d   = ipc_q;
        idx_d   = idx_q;

        if (redirect) begin
            pc_d    = redirect_addr;
            valid_d = 1'b0;
            idx_d   = 2'd0;
            raw_d   = '0;
            len_d   = 2'd0;
            // A request already on the bus cannot be withdrawn; absorb its ack first.
            if (req_q && !mem_ack) begin
                state_d = S_DRAIN;
            end else begin
                state_d = S_OP;
                req_d   = 1'b0;
            end
        end else begin
            case (state_q)
                S_OP: begin
                    if (!req_q) begin
                        req_d  = 1'b1;
                        addr_d = pc_q;
                    end else if (mem_ack) begin
                        raw_d = {24'h0, mem_rdata};
                        len_d = mem_rdata[7:6];
                        ipc_d = pc_q;
                        pc_d  = pc_q + 1'b1;
                        idx_d = 2'd1;
                        if (mem_rdata[7:6] == 2'd0) begin
                            state_d = S_HOLD;
                            req_d   = 1'b0;
                            valid_d = 1'b1;
                        end else begin
                            state_d = S_OPND;
                            addr_d  = pc_q + 1'b1;
                        end
                    end
                end
                S_OPND: begin
                    if (!req_q) begin
                        req_d  = 1'b1;
                        addr_d = pc_q;
                    end else if (mem_ack) begin
                        raw_d[{idx_q, 3'b000} +: 8] = mem_rdata;
                        pc_d  = pc_q + 1'b1;
                        idx_d = idx_q + 2'd1;
                        if (idx_q == len_q) begin
                            state_d = S_HOLD;
                            req_d   = 1'b0;
                            valid_d = 1'b1;
                        end else begin
                            addr_d = pc_q + 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        valid_d = 1'b0;
                        state_d = S_OP;
                    end
                end
                default: begin
                    if (mem_ack) begin
                        req_d   = 1'b0;
                        state_d = S_OP;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_OP;
            pc_q    <= RESET_VEC;
            req_q   <= 1'b0;
            addr_q  <= RESET_VEC;
            valid_q <= 1'b0;
            raw_q   <= '0;
            len_q   <= 2'd0;
            ipc_q   <= '0;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            raw_q   <= raw_d;
            len_q   <= len_d;
            ipc_q   <= ipc_d;
            idx_q   <= idx_d;
        end
    end

    assign mem_req   = req_q;
    assign mem_addr  = addr_q;
    assign out_valid = valid_q;
    assign raw       = raw_q;
    assign len       = len_q;
    assign insn_pc   = ipc_q;

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: a memory image plus an instruction-stream model
// that predicts each presented instruction and each fetch address.
module tb_ifu;

    localparam logic [15:0] RESET_VEC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] raw;
    logic [1:0]  len;
    logic [15:0] insn_pc;
    logic        redirect;
    logic [15:0] redirect_addr;

    logic [7:0] mem [0:65535];
    int waits = 0;
    int wcnt  = 0;
    logic stall = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    ifu #(.ADDR_W(16), .RESET_VEC(RESET_VEC)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .raw           (raw),
        .len           (len),
        .insn_pc       (insn_pc),
        .redirect      (redirect),
        .redirect_addr (redirect_addr)
    );

    always #5 clk = ~clk;

    // Memory with a programmable number of wait states; stall withholds ack.
    assign mem_ack   = mem_req && !stall && (wcnt >= waits);
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) wcnt <= (mem_req && !mem_ack) ? wcnt + 1 : 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] exp_raw(input logic [15:0] pc);
        logic [31:0] r;
        logic [15:0] a;
        int n;
        r = {24'h0, mem[pc]};
        n = int'(mem[pc][7:6]);
        for (int i = 1; i <= n; i++) begin
            a = pc + 16'(i);
            r[8*i +: 8] = mem[a];
        end
        return r;
    endfunction

    // Instruction-stream model: m_pc is the opcode address of the instruction
    // the ECU should see next; m_off counts bytes of it fetched so far.
    logic [15:0] m_pc;
    int          m_off;
    logic        m_drain;
    logic        prev_hold;
    logic [15:0] prev_addr;
    logic        prev_rst = 1'b0;

    always @(negedge clk) begin
        logic [31:0] e;
        logic [15:0] fa;
        if (rst) begin
            m_pc      = RESET_VEC;
            m_off     = 0;
            m_drain   = 1'b0;
            prev_hold = 1'b0;
            prev_rst  = 1'b1;
        end else begin
            if (prev_rst) begin
                check("m_rst_req", 32'(mem_req), 32'h0);
                check("m_rst_addr", 32'(mem_addr), 32'(RESET_VEC));
                check("m_rst_valid", 32'(out_valid), 32'h0);
                check("m_rst_raw", raw, 32'h0);
            end
            prev_rst = 1'b0;
            if (prev_hold) begin
                check("m_req_stable", 32'(mem_req), 32'h1);
                check("m_addr_stable", 32'(mem_addr), 32'(prev_addr));
            end
            if (out_valid) begin
                e = exp_raw(m_pc);
                check("m_raw", raw, e);
                check("m_len", 32'(len), 32'(e[7:6]));
                check("m_insn_pc", 32'(insn_pc), 32'(m_pc));
            end
            if (mem_req && mem_ack) begin
                if (m_drain) begin
                    m_drain = 1'b0;
                end else begin
                    fa = m_pc + 16'(m_off);
                    check("m_fetch_addr", 32'(mem_addr), 32'(fa));
                    check("m_fetch_count", 32'(m_off <= int'(mem[m_pc][7:6])), 32'h1);
                    m_off++;
                end
            end
            prev_hold = mem_req && !mem_ack;
            prev_addr = mem_addr;
            if (redirect) begin
                m_pc  = redirect_addr;
                m_off = 0;
                if (mem_req && !mem_ack) m_drain = 1'b1;
            end else if (out_valid && out_ready) begin
                m_pc  = m_pc + 16'(mem[m_pc][7:6]) + 16'd1;
                m_off = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [15:0] a);
        redirect      = 1'b1;
        redirect_addr = a;
        tick();
        redirect      = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 200) begin tick(); n++; end
        check("wait_valid", 32'(out_valid), 32'h1);
    endtask

    task automatic wait_req();
        int n = 0;
        while (!mem_req && n < 200) begin tick(); n++; end
        check("wait_req", 32'(mem_req), 32'h1);
    endtask

    task automatic wait_addr(input logic [15:0] a);
        int n = 0;
        while (!(mem_req && mem_addr == a) && n < 200) begin tick(); n++; end
        check("wait_addr", 32'(mem_addr), 32'(a));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0000] = 8'h05;
        mem[16'h0010] = 8'hC1; mem[16'h0011] = 8'hAA;
        mem[16'h0012] = 8'hBB; mem[16'h0013] = 8'hCC;
        mem[16'h0030] = 8'h42; mem[16'h0031] = 8'h7E;
        mem[16'h0020] = 8'h40; mem[16'h0021] = 8'h99;
        mem[16'h0100] = 8'h03;
        mem[16'hFFFF] = 8'h80;
        mem[16'h0040] = 8'hC0;

        rst = 1'b1; out_ready = 1'b0; redirect = 1'b0; redirect_addr = 16'h0;
        tick(); tick(); tick();
        check("rst_req", 32'(mem_req), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_addr", 32'(mem_addr), 32'h0000);
        check("rst_insn_pc", 32'(insn_pc), 32'h0000);

        // Zero-wait single-byte instruction: valid two cycles after OP entry.
        rst = 1'b0;
        tick();
        check("t1_req", 32'(mem_req), 32'h1);
        check("t1_valid_early", 32'(out_valid), 32'h0);
        tick();
        check("t1_valid", 32'(out_valid), 32'h1);
        check("t1_raw", raw, 32'h00000005);
        check("t1_len", 32'(len), 32'h0);
        check("t1_insn_pc", 32'(insn_pc), 32'h0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t1_hold_valid", 32'(out_valid), 32'h1);
            check("t1_hold_raw", raw, 32'h00000005);
            check("t1_hold_req", 32'(mem_req), 32'h0);
        end

        // Four-byte instruction after redirect, then the following fetch.
        do_redirect(16'h0010);
        wait_valid();
        check("t2_raw", raw, 32'hCCBBAAC1);
        check("t2_len", 32'(len), 32'h3);
        check("t2_insn_pc", 32'(insn_pc), 32'h0010);
        handshake();
        wait_req();
        check("t2_next_addr", 32'(mem_addr), 32'h0014);
        wait_valid();
        handshake();

        // Two wait states: each byte holds the request for three cycles.
        mem[16'h0000] = 8'h11;
        mem[16'h0001] = 8'h22;
        waits = 2;
        do_redirect(16'h0030);
        wait_req();
        check("t3_addr0", 32'(mem_addr), 32'h0030);
        check("t3_ack0", 32'(mem_ack), 32'h0);
        tick();
        check("t3_addr1", 32'({mem_req, mem_addr}), 32'h10030);
        check("t3_ack1", 32'(mem_ack), 32'h0);
        tick();
        check("t3_addr2", 32'({mem_req, mem_addr}), 32'h10030);
        check("t3_ack2", 32'(mem_ack), 32'h1);
        tick();
        check("t3_addr3", 32'({mem_req, mem_addr}), 32'h10031);
        wait_valid();
        check("t3_raw", raw, 32'h00007E42);
        check("t3_len", 32'(len), 32'h1);
        handshake();

        // Redirect while an operand request is pending: drain then refetch.
        waits = 3;
        do_redirect(16'h0020);
        wait_addr(16'h0021);
        stall = 1'b1;
        tick(); tick();
        do_redirect(16'h0100);
        for (int i = 0; i < 3; i++) begin
            check("t4_drain_addr", 32'({mem_req, mem_addr}), 32'h10021);
            check("t4_drain_valid", 32'(out_valid), 32'h0);
            tick();
        end
        stall = 1'b0;
        tick();
        check("t4_after_req", 32'(mem_req), 32'h0);
        check("t4_after_valid", 32'(out_valid), 32'h0);
        wait_req();
        check("t4_new_addr", 32'(mem_addr), 32'h0100);
        check("t4_new_valid", 32'(out_valid), 32'h0);
        wait_valid();
        check("t4_raw", raw, 32'h00000003);
        check("t4_insn_pc", 32'(insn_pc), 32'h0100);
        handshake();

        // Instruction straddling the address wrap.
        waits = 0;
        do_redirect(16'hFFFF);
        wait_valid();
        check("t5_raw", raw, 32'h00221180);
        check("t5_len", 32'(len), 32'h2);
        check("t5_insn_pc", 32'(insn_pc), 32'hFFFF);
        handshake();
        wait_req();
        check("t5_next_addr", 32'(mem_addr), 32'h0002);

        // Reset in the middle of an operand request.
        waits = 2;
        do_redirect(16'h0040);
        wait_addr(16'h0041);
        rst = 1'b1;
        tick();
        check("t6_req", 32'(mem_req), 32'h0);
        check("t6_valid", 32'(out_valid), 32'h0);
        check("t6_raw", raw, 32'h0);
        rst = 1'b0;
        wait_req();
        check("t6_restart_addr", 32'(mem_addr), 32'(RESET_VEC));
        wait_valid();
        check("t6_raw2", raw, 32'h00000011);
        check("t6_insn_pc", 32'(insn_pc), 32'h0000);
        handshake();
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ifu.md
Name: ifu

Overview:
- Instruction fetch unit: the producer side of the execution control unit's instruction-register load path.
- Reads a byte-wide instruction memory and assembles variable-length instructions of 1–4 bytes.
- Presents each instruction as a packed 32-bit word plus a 2-bit length over a valid/ready handshake; the ECU accepts it and loads its IR.
- Supports a branch redirect that flushes any partial or pending instruction.

Parameters:
- ADDR_W, 16, width of the byte address / program counter.
- RESET_VEC, 16'h0000, fetch address after reset.

Ports:
- clk  input  1  clock, all state updates on posedge
- rst  input  1  synchronous, active-high reset
- mem_req  output  1  byte read request, held until mem_ack
- mem_addr  output  ADDR_W  byte address of the current request
- mem_ack  input  1  read complete; mem_rdata valid this cycle
- mem_rdata  input  8  read data
- out_valid  output  1  raw/len/insn_pc hold a complete instruction
- out_ready  input  1  ECU accepts the instruction this cycle
- raw  output  32  [7:0]=opcode, [15:8]=d1, [23:16]=d2, [31:24]=d3; unused bytes are 0
- len  output  2  operand byte count (0..3) = opcode[7:6]
- insn_pc  output  ADDR_W  address of the opcode byte of the presented instruction
- redirect  input  1  discard current work and fetch from redirect_addr
- redirect_addr  input  ADDR_W  new fetch address

Behaviour:
- Reset (synchronous, active-high):
  - pc=RESET_VEC, state=OP, mem_req=0, mem_addr=RESET_VEC.
  - out_valid=0, raw=0, len=0, insn_pc=0, operand index=0, discard flag=0.
  - rst overrides redirect and any in-flight request.
- States: OP (fetch opcode), OPND (fetch operands), HOLD (present output), DRAIN (absorb an abandoned request).
- OP:
  - mem_req=1, mem_addr=pc.
  - On mem_ack: raw<=mem_rdata zero-extended, len<=mem_rdata[7:6], insn_pc<=pc, pc<=pc+1, idx<=1.
  - Next state is HOLD if mem_rdata[7:6]==0, else OPND.
- OPND:
  - mem_req=1, mem_addr=pc.
  - On mem_ack: raw byte[idx]<=mem_rdata, pc<=pc+1, idx<=idx+1.
  - When idx==len, go to HOLD.
- HOLD:
  - out_valid=1, mem_req=0.
  - raw, len and insn_pc are stable until the handshake completes.
  - On out_valid&&out_ready: out_valid<=0, go to OP; the first request issues the next cycle.
- Timing:
  - Minimum instruction latency is (len+1) memory transactions plus 1 cycle in HOLD.
  - With a zero-wait memory (ack in the same cycle as req), a 1-byte instruction produces out_valid 2 cycles after OP entry.
- mem_req protocol:
  - Once asserted, mem_req and mem_addr stay constant until mem_ack. The IFU never withdraws a request.
  - mem_ack without mem_req is ignored.
- PC arithmetic:
  - Modulo 2^ADDR_W. An instruction may straddle the wrap, e.g. opcode at FFFF and d1 at 0000.
  - insn_pc is the opcode address.
- redirect (priority below rst, above everything else), in any state:
  - pc<=redirect_addr, out_valid<=0, idx<=0, raw<=0, len<=0.
  - If mem_req=1 and mem_ack=0 this cycle, go to DRAIN; otherwise go to OP. A same-cycle ack's data is dropped.
- DRAIN:
  - mem_req=1, mem_addr unchanged (old address).
  - On mem_ack: discard data, go to OP.
  - A further redirect in DRAIN updates pc only and stays in DRAIN.
- redirect while out_valid&&out_ready in the same cycle: redirect wins; the ECU must treat the instruction as not transferred. The ECU does not assert both.
- No prefetch: at most one memory request is outstanding.
- Unknown and reserved opcodes are not checked; length comes only from opcode[7:6].

Test Plan:
- Reset, zero-wait memory with mem[0000]=0x05 -> after 2 cycles: out_valid=1, raw=0x00000005, len=0, insn_pc=0000; holds while out_ready=0.
- mem[0010..0013]=C1,AA,BB,CC, pc redirected to 0010 -> raw=0xCCBBAAC1, len=3, insn_pc=0010; after handshake, next fetch address is 0014.
- Memory with 2 wait states, instruction 0x42,0x7E -> mem_req stays high with constant mem_addr for 3 cycles per byte; raw=0x00007E42, len=1.
- redirect to 0100 while the OPND request at 0021 is pending (no ack) -> DRAIN holds addr 0021 until ack, data dropped; next request at 0100; no out_valid in between.
- ADDR_W=16, opcode 0x80 at FFFF, bytes 11,22 at 0000,0001 -> raw=0x00221180, insn_pc=FFFF, next fetch 0002.
- rst asserted in OPND mid-request -> next cycle mem_req=0, out_valid=0, raw=0; fetch restarts at RESET_VEC.
